// File: rtl/reg_writeback_unit_pkg.sv
// Shared types and widths for the register-file writeback path.
package reg_writeback_unit_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // One buffered mult/div result waiting for the write port.
  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding mult/div results until the write port is free.
// Push and pop may coincide at any fill level; a pop frees its slot first.
module wb_result_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  wb_entry_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (PW+1)'(1);
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Owner of the register-file write port: arbitrates in-order WB results against
// buffered mult/div results, forces a pipeline stall when the buffer starves,
// and tracks registers whose mult/div result is still in flight.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_issue,
  input  logic [REG_W-1:0]  md_issue_reg,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_reg,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              stall_req,
  input  logic [REG_W-1:0]  rd_reg_a,
  input  logic [REG_W-1:0]  rd_reg_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              regWriteF,
  output logic [REG_W-1:0]  writeReg,
  output logic [DATA_W-1:0] writeData
);

  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  logic              fifo_full, fifo_empty;
  wb_entry_t         fifo_head, md_entry;
  logic              md_push, pop, wb_win;

  logic              wf_q, wf_d;
  logic [REG_W-1:0]  wr_q, wr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              md_wr_q, md_wr_d;     // current write came from the FIFO
  logic [31:0]       sb_q, sb_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              stall_q, stall_d;

  assign md_ready  = !fifo_full;
  assign md_push   = md_valid && md_ready;
  assign md_entry  = '{wreg: md_reg, data: md_data};

  // Under stall the FIFO owns the port; otherwise WB has priority.
  assign pop       = !fifo_empty && (stall_q || !wb_valid);
  assign wb_win    = wb_valid && !stall_q;

  assign stall_req = stall_q;
  assign regWriteF = wf_q;
  assign writeReg  = wr_q;
  assign writeData = wd_q;

  // Lookups see only the registered scoreboard so a clear lands after the write.
  assign busy_a    = sb_q[rd_reg_a];
  assign busy_b    = sb_q[rd_reg_b];

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (md_push),
    .push_data_i (md_entry),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Winner selection, scoreboard update, starvation age and stall request.
  always_comb begin
    wf_d    = 1'b0;
    wr_d    = wr_q;
    wd_d    = wd_q;
    md_wr_d = 1'b0;
    if (pop) begin
      wf_d    = (fifo_head.wreg != REG_ZERO);
      wr_d    = fifo_head.wreg;
      wd_d    = fifo_head.data;
      md_wr_d = (fifo_head.wreg != REG_ZERO);
    end else if (wb_win) begin
      wf_d = (wb_reg != REG_ZERO);
      wr_d = wb_reg;
      wd_d = wb_data;
    end

    sb_d = sb_q;
    if (md_wr_q) sb_d[wr_q] = 1'b0;
    if (md_issue && md_issue_reg != REG_ZERO) sb_d[md_issue_reg] = 1'b1;

    if (fifo_empty || pop)                    age_d = '0;
    else if (age_q == AGE_W'(STARVE_MAX))     age_d = age_q;
    else                                      age_d = age_q + AGE_W'(1);

    if (stall_q) stall_d = !fifo_empty;
    else         stall_d = (age_q >= AGE_W'(STARVE_MAX));
  end

  // State registers; reset discards any in-progress write and pending bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      wf_q    <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
      md_wr_q <= 1'b0;
      sb_q    <= '0;
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      wf_q    <= wf_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      md_wr_q <= md_wr_d;
      sb_q    <= sb_d;
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  // Protocol checks: WB must respect the stall and never target a pending register.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(wb_valid && stall_q));
      assert (!(wb_valid && sb_q[wb_reg] && wb_reg != REG_ZERO));
    end
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the writeback rules.
module tb_reg_writeback_unit;
  import reg_writeback_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, md_issue, md_valid;
  logic [4:0]  wb_reg, md_issue_reg, md_reg, rd_reg_a, rd_reg_b;
  logic [31:0] wb_data, md_data;
  logic        md_ready, stall_req, busy_a, busy_b, regWriteF;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  always #5 clock = ~clock;

  reg_writeback_unit #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data),
    .md_ready(md_ready), .stall_req(stall_req),
    .rd_reg_a(rd_reg_a), .rd_reg_b(rd_reg_b), .busy_a(busy_a), .busy_b(busy_b),
    .regWriteF(regWriteF), .writeReg(writeReg), .writeData(writeData)
  );

  int nerr = 0;
  int nchk = 0;

  // Reference model state
  typedef struct { int r; logic [31:0] d; } ent_t;
  ent_t        q[$];
  bit   [31:0] sb;
  int          clr;      // register whose pending bit drops at the next edge
  int          age;
  bit          stall;
  bit          m_wf;
  int          m_wr;
  logic [31:0] m_wd;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); sb = '0; clr = -1; age = 0; stall = 0;
    m_wf = 0; m_wr = 0; m_wd = '0;
  endtask

  // Compare outputs for the current cycle, advance the model, cross one edge.
  task automatic tick();
    ent_t e;
    bit pre_ne, pop, xfer, nstall;
    bit [31:0] nsb;
    int nclr;
    #1;
    chk("regWriteF", {31'd0, regWriteF}, {31'd0, m_wf});
    if (m_wf) begin
      chk("writeReg", {27'd0, writeReg}, m_wr);
      chk("writeData", writeData, m_wd);
    end
    chk("stall_req", {31'd0, stall_req}, {31'd0, stall});
    chk("md_ready", {31'd0, md_ready}, {31'd0, q.size() < DEPTH});
    chk("busy_a", {31'd0, busy_a}, {31'd0, sb[rd_reg_a]});
    chk("busy_b", {31'd0, busy_b}, {31'd0, sb[rd_reg_b]});
    if (reset) model_reset();
    else begin
      pre_ne = (q.size() != 0);
      pop    = pre_ne && (stall || !wb_valid);
      xfer   = md_valid && (q.size() < DEPTH);
      nsb    = sb;
      if (clr > 0) nsb[clr] = 1'b0;
      if (md_issue && md_issue_reg != 0) nsb[md_issue_reg] = 1'b1;
      nclr = -1;
      m_wf = 0;
      if (pop) begin
        e = q.pop_front();
        m_wf = (e.r != 0); m_wr = e.r; m_wd = e.d;
        if (e.r != 0) nclr = e.r;
      end else if (wb_valid && !stall) begin
        m_wf = (wb_reg != 0); m_wr = wb_reg; m_wd = wb_data;
      end
      nstall = stall ? pre_ne : (age >= SMAX);
      age    = (!pre_ne || pop) ? 0 : ((age < SMAX) ? age + 1 : age);
      if (xfer) q.push_back('{r: md_reg, d: md_data});
      sb = nsb; clr = nclr; stall = nstall;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    wb_valid = 0; md_issue = 0; md_valid = 0;
  endtask

  initial begin
    int writes;
    int r;
    reset = 1; idle_inputs();
    wb_reg = 0; wb_data = 0; md_issue_reg = 0; md_reg = 0; md_data = 0;
    rd_reg_a = 9; rd_reg_b = 10;
    model_reset();
    @(negedge clock); @(negedge clock); @(negedge clock);
    reset = 0;

    // 1: idle after reset
    repeat (5) tick();
    #1;
    chk("t1_wf", {31'd0, regWriteF}, 0);
    chk("t1_busy_a", {31'd0, busy_a}, 0);
    chk("t1_busy_b", {31'd0, busy_b}, 0);
    chk("t1_md_ready", {31'd0, md_ready}, 1);
    chk("t1_stall", {31'd0, stall_req}, 0);

    // 2: plain WB writes, including reg 0
    wb_valid = 1; wb_reg = 8; wb_data = 32'hDEADBEEF; tick();
    wb_reg = 0; wb_data = 32'h1;
    chk("t2_wf", {31'd0, regWriteF}, 1);
    chk("t2_wr", {27'd0, writeReg}, 8);
    chk("t2_wd", writeData, 32'hDEADBEEF);
    tick(); wb_valid = 0;
    chk("t2_r0_wf", {31'd0, regWriteF}, 0);

    // 3: single mult/div round trip on reg 9
    md_issue = 1; md_issue_reg = 9; rd_reg_a = 9; tick(); md_issue = 0;
    chk("t3_busy_set", {31'd0, busy_a}, 1);
    md_valid = 1; md_reg = 9; md_data = 32'h12345678; tick(); md_valid = 0;
    chk("t3_push_wf", {31'd0, regWriteF}, 0);
    tick();
    chk("t3_wf", {31'd0, regWriteF}, 1);
    chk("t3_wr", {27'd0, writeReg}, 9);
    chk("t3_wd", writeData, 32'h12345678);
    chk("t3_busy_hold", {31'd0, busy_a}, 1);
    tick();
    chk("t3_busy_clr", {31'd0, busy_a}, 0);

    // 4: starvation under continuous WB traffic
    md_issue = 1; md_issue_reg = 20; tick();
    md_issue_reg = 21; tick(); md_issue = 0;
    rd_reg_a = 20; rd_reg_b = 21;
    wb_valid = 1;
    for (int i = 0; i < 6; i++) begin
      wb_reg = 5'(i + 1); wb_data = $urandom;
      md_valid = (i < 2); md_reg = 5'(20 + i); md_data = 32'hA000_0000 + i;
      tick();
      if (i == 1) chk("t4_full", {31'd0, md_ready}, 0);
      if (i == 4) chk("t4_no_stall_yet", {31'd0, stall_req}, 0);
    end
    chk("t4_stall", {31'd0, stall_req}, 1);
    wb_valid = 0; md_valid = 0; tick();
    chk("t4_d0_wr", {27'd0, writeReg}, 20);
    chk("t4_d0_wd", writeData, 32'hA000_0000);
    chk("t4_busy20_hold", {31'd0, busy_a}, 1);
    tick();
    chk("t4_d1_wf", {31'd0, regWriteF}, 1);
    chk("t4_d1_wr", {27'd0, writeReg}, 21);
    chk("t4_stall_hold", {31'd0, stall_req}, 1);
    chk("t4_busy20_clr", {31'd0, busy_a}, 0);
    tick();
    chk("t4_stall_drop", {31'd0, stall_req}, 0);
    chk("t4_busy21_clr", {31'd0, busy_b}, 0);

    // 5: streaming push+pop every cycle, pointers wrap several times
    for (int i = 0; i < 10; i++) begin
      md_valid = 1; md_reg = 5'(11 + i); md_data = 32'h5000_0000 + i;
      tick();
      if (i > 0) chk("t5_wd", writeData, 32'h5000_0000 + i - 1);
    end
    md_valid = 0; tick();
    chk("t5_last_wd", writeData, 32'h5000_0009);
    chk("t5_last_wr", {27'd0, writeReg}, 20);
    tick();

    // 6: reset with buffered results and pending registers
    rd_reg_a = 9; rd_reg_b = 10;
    md_issue = 1; md_issue_reg = 9; tick();
    md_issue_reg = 10; tick(); md_issue = 0;
    wb_valid = 1;
    for (int i = 0; i < 2; i++) begin
      wb_reg = 5'(3 + i); wb_data = $urandom;
      md_valid = 1; md_reg = 5'(9 + i); md_data = 32'hC000_0000 + i;
      tick();
    end
    md_valid = 0;
    chk("t6_full", {31'd0, md_ready}, 0);
    chk("t6_busy9", {31'd0, busy_a}, 1);
    wb_valid = 0; reset = 1; tick(); reset = 0;
    chk("t6_wf", {31'd0, regWriteF}, 0);
    chk("t6_busy9_clr", {31'd0, busy_a}, 0);
    chk("t6_busy10_clr", {31'd0, busy_b}, 0);
    chk("t6_md_ready", {31'd0, md_ready}, 1);
    chk("t6_stall", {31'd0, stall_req}, 0);
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (regWriteF) writes++;
    end
    chk("t6_no_stale_write", writes, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 399) == 0);
      md_issue     = ($urandom_range(0, 3) == 0);
      md_issue_reg = 5'($urandom_range(0, 31));
      r            = $urandom_range(0, 31);
      wb_valid     = !stall && !sb[r] &&
                     ($urandom_range(0, 99) < (((n / 200) % 2) ? 90 : 40));
      wb_reg       = 5'(r);
      wb_data      = $urandom;
      md_valid     = ($urandom_range(0, 2) == 0);
      md_reg       = 5'($urandom_range(0, 31));
      md_data      = $urandom;
      rd_reg_a     = 5'($urandom_range(0, 31));
      rd_reg_b     = 5'($urandom_range(0, 31));
      tick();
    end
    reset = 0; idle_inputs();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
